// File: rtl/commit_mem_write_sched_pkg.sv
// Shared types and encodings for the commit-stage memory write scheduler.
//   LSWIDTH_*      : load/store width encodings carried with every write
//   AXI_BRESP_*    : AXI B response codes
//   wr_req_t       : one write request payload (addr/strb/lswidth/data/uncached)
//   slot_state_t   : occupancy of the single registered request slot
package commit_mem_write_sched_pkg;

  localparam logic [1:0] LSWIDTH_BYTE = 2'd0;
  localparam logic [1:0] LSWIDTH_HALF = 2'd1;
  localparam logic [1:0] LSWIDTH_WORD = 2'd2;

  localparam logic [1:0] AXI_BRESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_BRESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_BRESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_BRESP_DECERR = 2'b11;

  localparam int NUM_REQ = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [1:0]  lswidth;
    logic [31:0] data;
    logic        uncached;
  } wr_req_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Anything other than OKAY is reported as a write error; EXOKAY is not
  // expected for plain committed stores and is treated as an error too.
  function automatic logic bresp_is_err(input logic [1:0] resp);
    return resp != AXI_BRESP_OKAY;
  endfunction

endpackage

// File: rtl/commit_mem_write_rr2.sv
// Two-way round-robin arbiter.
//   clk, resetn : clock, async active-low reset
//   valid[1:0]  : per-requester request
//   en          : grants are allowed this cycle
//   grant[1:0]  : one-hot grant (combinational), all-zero when en=0
// The pointer names the favoured requester and moves away from whichever
// requester was granted, so a lone requester never starves the other.
module commit_mem_write_rr2
  import commit_mem_write_sched_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] valid,
  input  logic       en,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
      else                grant = valid;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       ptr <= 1'b0;
    else if (|grant)   ptr <= grant[0];
  end

endmodule

// File: rtl/commit_mem_write_sched.sv
// Commit-stage memory write scheduler.
// Arbitrates the store-commit path (req0) and the cache-eviction path (req1)
// into one registered slot that feeds the AXI write controller, tracks
// writes still waiting for a B response, and reports drain/error status.
//   clk, resetn               : clock, async active-low reset
//   i_reqN_* / o_reqN_ready   : requester N handshake and payload
//   o_wbmem_*                 : slot contents toward the write controller
//   i_wbmem_en                : controller took the slot this cycle
//   i_axi_bvalid/i_axi_bresp  : B channel observation
//   i_fence                   : stop granting until drained
//   i_err_clr                 : clear sticky error flags
//   o_idle                    : slot empty and nothing outstanding
//   o_bresp_err               : sticky non-OKAY response seen
//   o_cnt_underflow           : sticky B response with nothing outstanding
module commit_mem_write_sched
  import commit_mem_write_sched_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic [31:0] i_req0_addr,
  input  logic [3:0]  i_req0_strb,
  input  logic [1:0]  i_req0_lswidth,
  input  logic [31:0] i_req0_data,
  input  logic        i_req0_uncached,
  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic [31:0] i_req1_addr,
  input  logic [3:0]  i_req1_strb,
  input  logic [1:0]  i_req1_lswidth,
  input  logic [31:0] i_req1_data,
  input  logic        i_req1_uncached,
  output logic        o_wbmem_valid,
  output logic [31:0] o_wbmem_addr,
  output logic [3:0]  o_wbmem_strb,
  output logic [1:0]  o_wbmem_lswidth,
  output logic [31:0] o_wbmem_data,
  output logic        o_wbmem_uncached,
  input  logic        i_wbmem_en,
  input  logic        i_axi_bvalid,
  input  logic [1:0]  i_axi_bresp,
  input  logic        i_fence,
  input  logic        i_err_clr,
  output logic        o_idle,
  output logic        o_bresp_err,
  output logic        o_cnt_underflow
);

  localparam logic [CNT_W:0] MAX_OUT = (CNT_W+1)'(MAX_OUTSTANDING);

  slot_state_t      state;
  wr_req_t          slot;
  wr_req_t          req [NUM_REQ];
  logic [1:0]       req_valid;
  logic [1:0]       grant;
  logic [CNT_W-1:0] cnt;
  logic             full;
  logic             grant_ok;
  logic             any_grant;
  logic             accept;
  logic             dec;
  logic             underflow_set;
  logic             err_set;

  assign req[0]    = '{addr: i_req0_addr, strb: i_req0_strb, lswidth: i_req0_lswidth,
                       data: i_req0_data, uncached: i_req0_uncached};
  assign req[1]    = '{addr: i_req1_addr, strb: i_req1_strb, lswidth: i_req1_lswidth,
                       data: i_req1_data, uncached: i_req1_uncached};
  assign req_valid = {i_req1_valid, i_req0_valid};

  assign full   = (state == SLOT_FULL);
  assign accept = full && i_wbmem_en;

  // The slot counts against the cap; a B response arriving this same cycle
  // is deliberately not credited so the check stays off the bvalid path.
  assign grant_ok = (!full || i_wbmem_en) && !i_fence &&
                    (({1'b0, cnt} + (CNT_W+1)'(full)) < MAX_OUT);

  commit_mem_write_rr2 u_rr (
    .clk    (clk),
    .resetn (resetn),
    .valid  (req_valid),
    .en     (grant_ok),
    .grant  (grant)
  );

  assign o_req0_ready = grant[0];
  assign o_req1_ready = grant[1];
  assign any_grant    = |grant;

  // Slot: refilled in the same cycle it is accepted, so back-to-back writes
  // see no bubble. Payload only changes on a grant.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= SLOT_EMPTY;
      slot  <= '0;
    end else begin
      case (state)
        SLOT_EMPTY: if (any_grant) state <= SLOT_FULL;
        SLOT_FULL:  if (i_wbmem_en && !any_grant) state <= SLOT_EMPTY;
        default:    state <= SLOT_EMPTY;
      endcase
      if (any_grant) slot <= grant[1] ? req[1] : req[0];
    end
  end

  assign o_wbmem_valid    = full;
  assign o_wbmem_addr     = slot.addr;
  assign o_wbmem_strb     = slot.strb;
  assign o_wbmem_lswidth  = slot.lswidth;
  assign o_wbmem_data     = slot.data;
  assign o_wbmem_uncached = slot.uncached;

  // A B response alongside an accept nets to zero even when cnt is 0, so it
  // is not an underflow in that case.
  assign dec           = i_axi_bvalid && ((cnt != '0) || accept);
  assign underflow_set = i_axi_bvalid && (cnt == '0) && !accept;
  assign err_set       = i_axi_bvalid && bresp_is_err(i_axi_bresp);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else begin
      case ({accept, dec})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      o_bresp_err     <= 1'b0;
      o_cnt_underflow <= 1'b0;
    end else begin
      o_bresp_err     <= err_set       || (o_bresp_err     && !i_err_clr);
      o_cnt_underflow <= underflow_set || (o_cnt_underflow && !i_err_clr);
    end
  end

  assign o_idle = !full && (cnt == '0);

endmodule

// File: tb/tb_commit_mem_write_sched.sv
module tb_commit_mem_write_sched;
  import commit_mem_write_sched_pkg::*;

  localparam int MAX = 4;

  logic clk = 0;
  logic resetn = 0;
  always #5 clk = ~clk;

  logic        v0, v1, r0, r1, wv, en, bv, fence, eclr, idle, berr, uflow;
  wr_req_t     p0, p1;
  logic [31:0] waddr, wdata;
  logic [3:0]  wstrb;
  logic [1:0]  wlsw, bresp;
  logic        wunc;

  commit_mem_write_sched #(.MAX_OUTSTANDING(MAX), .CNT_W(4)) dut (
    .clk(clk), .resetn(resetn),
    .i_req0_valid(v0), .o_req0_ready(r0),
    .i_req0_addr(p0.addr), .i_req0_strb(p0.strb), .i_req0_lswidth(p0.lswidth),
    .i_req0_data(p0.data), .i_req0_uncached(p0.uncached),
    .i_req1_valid(v1), .o_req1_ready(r1),
    .i_req1_addr(p1.addr), .i_req1_strb(p1.strb), .i_req1_lswidth(p1.lswidth),
    .i_req1_data(p1.data), .i_req1_uncached(p1.uncached),
    .o_wbmem_valid(wv), .o_wbmem_addr(waddr), .o_wbmem_strb(wstrb),
    .o_wbmem_lswidth(wlsw), .o_wbmem_data(wdata), .o_wbmem_uncached(wunc),
    .i_wbmem_en(en), .i_axi_bvalid(bv), .i_axi_bresp(bresp),
    .i_fence(fence), .i_err_clr(eclr),
    .o_idle(idle), .o_bresp_err(berr), .o_cnt_underflow(uflow)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: slot as a queue of at most one write, outstanding
  // writes as a plain integer, and which requester is next in line.
  wr_req_t m_slot[$];
  int      m_cnt;
  int      m_next;
  bit      m_berr, m_uflow;
  bit      lg0, lg1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic wr_req_t rnd_req();
    wr_req_t r;
    r.addr = $urandom; r.strb = 4'($urandom); r.lswidth = 2'($urandom_range(0, 2));
    r.data = $urandom; r.uncached = 1'($urandom);
    return r;
  endfunction

  task automatic model_reset();
    m_slot.delete(); m_cnt = 0; m_next = 0; m_berr = 0; m_uflow = 0;
  endtask

  // Which requester should be granted this cycle, from model state.
  task automatic predict(output bit g0, output bit g1);
    int occ;
    bit ok;
    occ = m_slot.size();
    ok  = (occ == 0 || en) && !fence && (m_cnt + occ < MAX);
    g0 = 0; g1 = 0;
    if (ok) begin
      if (v0 && v1) begin g0 = (m_next == 0); g1 = (m_next == 1); end
      else begin g0 = v0; g1 = v1; end
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".valid"}, 128'(wv), 128'(m_slot.size() == 1));
    if (m_slot.size() == 1)
      chk({tag, ".payload"}, 128'({waddr, wstrb, wlsw, wdata, wunc}), 128'(m_slot[0]));
    chk({tag, ".idle"}, 128'(idle), 128'(m_slot.size() == 0 && m_cnt == 0));
    chk({tag, ".berr"}, 128'(berr), 128'(m_berr));
    chk({tag, ".uflow"}, 128'(uflow), 128'(m_uflow));
  endtask

  // One clock: inputs were set after the falling edge by the caller.
  task automatic cyc(input string tag);
    bit g0, g1, acc, bset;
    #1;
    predict(g0, g1);
    chk({tag, ".rdy0"}, 128'(r0), 128'(g0));
    chk({tag, ".rdy1"}, 128'(r1), 128'(g1));
    lg0 = g0; lg1 = g1;
    @(posedge clk);
    acc = en && m_slot.size() == 1;
    if (acc) void'(m_slot.pop_front());
    if (g0) begin m_slot.push_back(p0); m_next = 1; end
    if (g1) begin m_slot.push_back(p1); m_next = 0; end
    if (bv && m_cnt == 0 && !acc) begin
      m_uflow = 1;
    end else begin
      m_cnt = m_cnt + (acc ? 1 : 0) - (bv ? 1 : 0);
      if (m_uflow && eclr) m_uflow = 0;
    end
    bset = bv && bresp != 2'b00;
    m_berr = bset || (m_berr && !eclr);
    #1;
    check_state(tag);
    @(negedge clk);
  endtask

  task automatic idle_in();
    v0 = 0; v1 = 0; en = 0; bv = 0; bresp = 0; fence = 0; eclr = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && !(m_slot.size() == 0 && m_cnt == 0); i++) begin
      idle_in(); en = (m_slot.size() == 1); bv = (m_cnt > 0);
      cyc("drain");
    end
    idle_in();
    chk("drain.done", 128'(idle), 128'(1));
  endtask

  int  ng;
  bit  first;
  wr_req_t tmp;

  initial begin
    idle_in();
    p0 = '0; p1 = '0;
    model_reset();
    #12;
    chk("reset.idle", 128'(idle), 128'(1));
    chk("reset.valid", 128'(wv), 128'(0));
    chk("reset.flags", 128'({berr, uflow}), 128'(0));
    @(negedge clk); resetn = 1; @(negedge clk);

    // Single write.
    v0 = 1; p0 = '{addr: 32'h1000_0040, strb: 4'hF, lswidth: LSWIDTH_WORD,
                   data: 32'hDEAD_BEEF, uncached: 1'b0};
    cyc("single.grant");
    chk("single.valid", 128'(wv), 128'(1));
    chk("single.addr", 128'(waddr), 128'(32'h1000_0040));
    v0 = 0; p0 = rnd_req();
    cyc("single.hold1");
    chk("single.data", 128'(wdata), 128'(32'hDEAD_BEEF));
    en = 1;
    cyc("single.accept");
    chk("single.notidle", 128'(idle), 128'(0));
    en = 0; bv = 1; bresp = AXI_BRESP_OKAY;
    cyc("single.bresp");
    chk("single.idle", 128'(idle), 128'(1));
    idle_in();

    // Contention: req0 granted last, so req1 goes first and then they alternate.
    for (int i = 0; i < 6; i++) begin
      v0 = 1; v1 = 1; p0 = rnd_req(); p1 = rnd_req();
      en = (m_slot.size() == 1); bv = (m_cnt > 0);
      cyc("contend");
      chk("contend.order", 128'({lg1, lg0}), 128'((i % 2 == 0) ? 2'b10 : 2'b01));
    end
    drain();

    // Outstanding cap.
    ng = 0;
    for (int i = 0; i < 8; i++) begin
      v0 = 1; v1 = 1; p0 = rnd_req(); p1 = rnd_req(); en = 1;
      cyc("cap");
      ng += int'(lg0) + int'(lg1);
    end
    chk("cap.grants", 128'(ng), 128'(4));
    ng = 0;
    bv = 1; cyc("cap.b");
    ng += int'(lg0) + int'(lg1);
    bv = 0; cyc("cap.after");
    ng += int'(lg0) + int'(lg1);
    chk("cap.one_more", 128'(ng), 128'(1));
    drain();

    // Fence: build count=2 with slot full.
    v0 = 1; p0 = rnd_req(); cyc("fence.f1");
    en = 1; p0 = rnd_req(); cyc("fence.f2");
    p0 = rnd_req(); cyc("fence.f3");
    fence = 1; v1 = 1; p1 = rnd_req(); en = 1;
    cyc("fence.blk");
    chk("fence.noready", 128'({r1, r0}), 128'(0));
    en = 0; bv = 1;
    cyc("fence.b1"); cyc("fence.b2");
    chk("fence.busy", 128'(idle), 128'(0));
    cyc("fence.b3");
    chk("fence.idle", 128'(idle), 128'(1));
    bv = 0; fence = 0;
    cyc("fence.release");
    chk("fence.resume", 128'(wv), 128'(1));
    drain();

    // Simultaneous accept and B, then an error response.
    v0 = 1; p0 = rnd_req(); cyc("sim.f1");
    en = 1; p0 = rnd_req(); cyc("sim.f2");
    p0 = rnd_req(); cyc("sim.f3");
    v0 = 0; bv = 1; cyc("sim.both");
    en = 0; bresp = AXI_BRESP_SLVERR; cyc("sim.err");
    chk("sim.berr", 128'(berr), 128'(1));
    chk("sim.cnt_kept", 128'(idle), 128'(0));
    bresp = AXI_BRESP_OKAY; cyc("sim.last");
    chk("sim.idle", 128'(idle), 128'(1));
    bv = 0; cyc("sim.sticky");
    chk("sim.stays", 128'(berr), 128'(1));
    eclr = 1; cyc("sim.clr");
    chk("sim.cleared", 128'(berr), 128'(0));
    eclr = 0; bv = 1; cyc("uflow.set");
    chk("uflow.flag", 128'(uflow), 128'(1));
    bv = 0; eclr = 1; cyc("uflow.clr");
    idle_in();

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      v0 = ($urandom_range(0, 9) < 6); v1 = ($urandom_range(0, 9) < 5);
      p0 = rnd_req(); p1 = rnd_req();
      en = 1'($urandom);
      bv = (m_cnt > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 49) == 0);
      bresp = ($urandom_range(0, 15) == 0) ? 2'($urandom) : AXI_BRESP_OKAY;
      fence = ($urandom_range(0, 9) == 0);
      eclr = ($urandom_range(0, 19) == 0);
      cyc("rand");
    end
    drain();

    // Async reset mid-write: slot full, count=3.
    v0 = 1; p0 = rnd_req(); cyc("rst.f1");
    en = 1;
    for (int i = 0; i < 3; i++) begin p0 = rnd_req(); cyc("rst.fill"); end
    chk("rst.busy", 128'(wv), 128'(1));
    #2 resetn = 0;
    #1;
    model_reset();
    chk("rst.valid", 128'(wv), 128'(0));
    chk("rst.idle", 128'(idle), 128'(1));
    chk("rst.addr", 128'(waddr), 128'(0));
    @(negedge clk); idle_in(); resetn = 1;
    v0 = 1; p0 = rnd_req(); cyc("rst.after");
    idle_in(); drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
